// File: rtl/fma_share_arbiter.sv
// rtl/fma_share_arbiter.sv - round-robin arbiter sharing one combinational FMA among N_REQ requesters
module fma_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int LAT   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  input  logic [32*N_REQ-1:0]  req_c,
  output logic [31:0]          fma_a,
  output logic [31:0]          fma_b,
  output logic [31:0]          fma_c,
  input  logic [31:0]          fma_d,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_data,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic                 busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] tag;
  logic [CW-1:0] cnt;

  logic          grant_found;
  logic [PW-1:0] grant_idx;

  // Search ascends from ptr, wrapping at N_REQ; first asserted request wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!grant_found && req_valid[j]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(j);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && grant_found) req_ready = N_REQ'(1) << grant_idx;
  end

  always_comb begin
    rsp_valid = '0;
    if (!rst && state == RESP) rsp_valid = N_REQ'(1) << tag;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      tag      <= '0;
      cnt      <= '0;
      fma_a    <= '0;
      fma_b    <= '0;
      fma_c    <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            ptr   <= (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            fma_a <= req_a[32*grant_idx +: 32];
            fma_b <= req_b[32*grant_idx +: 32];
            fma_c <= req_c[32*grant_idx +: 32];
            tag   <= grant_idx;
            cnt   <= CW'(LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          // Operands have been stable for LAT cycles once cnt reaches zero.
          if (cnt == '0) begin
            rsp_data <= fma_d;
            state    <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[tag]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fma_share_arbiter.sv
// tb/tb_fma_share_arbiter.sv - directed self-checking bench for fma_share_arbiter
module tb_fma_share_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [127:0] req_a, req_b, req_c;
  logic [31:0]  fma_a, fma_b, fma_c, fma_d, rsp_data;
  logic         busy;

  logic [1:0]   l_req_valid, l_req_ready, l_rsp_valid, l_rsp_ready;
  logic [63:0]  l_req_a, l_req_b, l_req_c;
  logic [31:0]  l_fma_a, l_fma_b, l_fma_c, l_fma_d, l_rsp_data;
  logic         l_busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Stand-in FMA: exact for the 1*2+3 case, otherwise an operand-sensitive scramble.
  function automatic logic [31:0] fma_model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && c == 32'h4040_0000) return 32'h40A0_0000;
    return (a ^ {b[15:0], b[31:16]}) + c;
  endfunction

  assign fma_d   = fma_model(fma_a, fma_b, fma_c);
  assign l_fma_d = fma_model(l_fma_a, l_fma_b, l_fma_c);

  fma_share_arbiter #(.N_REQ(4), .LAT(3)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_d(fma_d),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
  );

  fma_share_arbiter #(.N_REQ(2), .LAT(1)) u_dut_lat1 (
    .clk(clk), .rst(rst), .req_valid(l_req_valid), .req_ready(l_req_ready),
    .req_a(l_req_a), .req_b(l_req_b), .req_c(l_req_c),
    .fma_a(l_fma_a), .fma_b(l_fma_b), .fma_c(l_fma_c), .fma_d(l_fma_d),
    .rsp_valid(l_rsp_valid), .rsp_data(l_rsp_data), .rsp_ready(l_rsp_ready), .busy(l_busy)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] slice_model(input int g);
    return fma_model(req_a[32*g +: 32], req_b[32*g +: 32], req_c[32*g +: 32]);
  endfunction

  initial begin
    rst = 1'b1;
    req_valid = 4'hF; rsp_ready = 4'h0;
    req_a = '0; req_b = '0; req_c = '0;
    l_req_valid = 2'b11; l_rsp_ready = 2'b00;
    l_req_a = '0; l_req_b = '0; l_req_c = '0;

    // Reset state, with requests asserted while rst is high
    tick;
    chk("rst_req_ready", req_ready, 4'h0);
    chk("rst_rsp_valid", rsp_valid, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fma_a", fma_a, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_l_req_ready", l_req_ready, 2'b00);
    rst = 1'b0;
    req_valid = 4'h0; l_req_valid = 2'b00;

    // Single op: requester 2, 1.0*2.0+3.0
    tick;
    req_a[95:64] = 32'h3F80_0000; req_b[95:64] = 32'h4000_0000; req_c[95:64] = 32'h4040_0000;
    req_valid = 4'b0100; rsp_ready = 4'hF;
    #1;
    chk("single_grant", req_ready, 4'b0100);
    chk("single_busy_c0", busy, 1'b0);
    tick;
    req_valid = 4'b0001;
    req_a[31:0] = 32'hDEAD_BEEF;
    #1;
    chk("single_busy_c1", busy, 1'b1);
    chk("single_fma_a", fma_a, 32'h3F80_0000);
    chk("single_fma_b", fma_b, 32'h4000_0000);
    chk("single_fma_c", fma_c, 32'h4040_0000);
    chk("single_ready_wait", req_ready, 4'h0);
    tick;
    req_valid = 4'h0;
    chk("single_rsp_c2", rsp_valid, 4'h0);
    tick;
    chk("single_rsp_c3", rsp_valid, 4'h0);
    chk("single_busy_c3", busy, 1'b1);
    tick;
    chk("single_rsp_valid", rsp_valid, 4'b0100);
    chk("single_rsp_data", rsp_data, 32'h40A0_0000);
    chk("single_busy_c4", busy, 1'b1);
    chk("single_fma_hold", fma_a, 32'h3F80_0000);
    tick;
    chk("single_busy_c5", busy, 1'b0);
    chk("single_rsp_c5", rsp_valid, 4'h0);

    // All four requesting after reset: grants 0,1,2,3 spaced 5 cycles
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      req_a[32*g +: 32] = 32'h1111_0000 * (g + 1) + 32'h5;
      req_b[32*g +: 32] = 32'h0003_0700 + g;
      req_c[32*g +: 32] = 32'h0100_0000 << g;
    end
    req_valid = 4'hF; rsp_ready = 4'hF;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("rr_grant", req_ready, 64'(1) << g);
      tick;
      req_valid[g] = 1'b0;
      tick;
      tick;
      tick;
      chk("rr_rsp_valid", rsp_valid, 64'(1) << g);
      chk("rr_rsp_data", rsp_data, slice_model(g));
      tick;
    end

    // Fairness: req0 and req3 held continuously
    req_valid = 4'b1001;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("fair_grant", req_ready, (n % 2 == 0) ? 4'b0001 : 4'b1000);
      tick; tick; tick; tick; tick;
    end
    req_valid = 4'h0;

    // Backpressure: other rsp_ready bits high must be ignored
    tick;
    req_valid = 4'b0001; rsp_ready = 4'b1110;
    #1;
    chk("bp_grant", req_ready, 4'b0001);
    tick;
    req_valid = 4'b0010;
    tick; tick; tick;
    for (int n = 0; n < 5; n++) begin
      chk("bp_rsp_valid", rsp_valid, 4'b0001);
      chk("bp_rsp_data", rsp_data, slice_model(0));
      chk("bp_req_ready", req_ready, 4'h0);
      tick;
    end
    rsp_ready = 4'hF;
    #1;
    chk("bp_release_valid", rsp_valid, 4'b0001);
    chk("bp_release_ready", req_ready, 4'h0);
    tick;
    chk("bp_next_grant", req_ready, 4'b0010);
    tick;
    req_valid = 4'h0;
    tick; tick; tick;
    chk("bp_req1_rsp", rsp_valid, 4'b0010);
    chk("bp_req1_data", rsp_data, slice_model(1));
    tick;

    // Reset during second WAIT cycle abandons the op and clears ptr
    req_valid = 4'b0100;
    #1;
    chk("abort_grant", req_ready, 4'b0100);
    tick;
    req_valid = 4'h0;
    tick;
    rst = 1'b1;
    #1;
    chk("abort_rsp_in_rst", rsp_valid, 4'h0);
    tick;
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    for (int n = 0; n < 4; n++) begin
      tick;
      chk("abort_no_rsp", rsp_valid, 4'h0);
    end
    req_valid = 4'b0011;
    #1;
    chk("abort_ptr0_grant", req_ready, 4'b0001);
    tick;
    req_valid = 4'h0;

    // LAT=1 corner on the second instance
    l_req_a[31:0] = 32'h0123_4567; l_req_b[31:0] = 32'h89AB_CDEF; l_req_c[31:0] = 32'h0000_1000;
    l_req_valid = 2'b01; l_rsp_ready = 2'b11;
    #1;
    chk("lat1_grant", l_req_ready, 2'b01);
    tick;
    l_req_valid = 2'b00;
    chk("lat1_busy_c1", l_busy, 1'b1);
    chk("lat1_rsp_c1", l_rsp_valid, 2'b00);
    tick;
    chk("lat1_rsp_c2", l_rsp_valid, 2'b01);
    chk("lat1_data", l_rsp_data, fma_model(32'h0123_4567, 32'h89AB_CDEF, 32'h0000_1000));
    tick;
    chk("lat1_idle_c3", l_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
